ifc_block_xfer_ctrl: RTL and testbench

- Sequences IFC block transfers through the CPLD handshake/data register window: 0x40 control/status, 0x50 checksum, 0x52 byte length, 0x54 auto-increment data port.
- Owns the shared block buffer of DEPTH 16-bit words and arbitrates it between the IFC host and the local agent (UART/FPGA side).
- Sits between the IFC address/strobe decoder and the data_block storage.

---
 rtl/ifc_block_xfer_ctrl_pkg.sv | 57 +++++
 rtl/ifc_block_xfer_ctrl_if.sv | 37 +++
 rtl/ifc_block_xfer_ctrl_buf.sv | 60 ++++++
 rtl/ifc_block_xfer_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ifc_block_xfer_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ifc_block_xfer_ctrl_pkg.sv
// ifc_xfer_pkg: shared constants and types for the IFC block transfer controller.
// Holds the register window addresses, control words, status bit positions,
// the FSM state encoding and a helper that maps a state onto its status class.
package ifc_xfer_pkg;

  localparam int DATA_W = 16;

  // Register window
  localparam logic [7:0] ADDR_CTRL = 8'h40;
  localparam logic [7:0] ADDR_CSUM = 8'h50;
  localparam logic [7:0] ADDR_LEN  = 8'h52;
  localparam logic [7:0] ADDR_DATA = 8'h54;

  // Control words; bit 8 is the key that qualifies any control write
  localparam logic [15:0] CMD_END = 16'h0100;
  localparam logic [15:0] CMD_RD  = 16'h0103;
  localparam logic [15:0] CMD_WR  = 16'h0105;
  localparam int          KEY_BIT = 8;

  // Status word bit positions
  localparam int ST_READY = 3;
  localparam int ST_WOK   = 4;
  localparam int ST_CERR  = 5;
  localparam int ST_LERR  = 6;
  localparam int ST_SERR  = 7;
  localparam int ST_KEY   = 8;
  localparam int ST_CLS   = 9;   // two bits, [10:9]

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_RD_FILL  = 3'b001,
    S_RD_READY = 3'b010,
    S_WR_RECV  = 3'b100,
    S_WR_CHECK = 3'b101,
    S_WR_DRAIN = 3'b110,
    S_ERR      = 3'b111
  } xfer_state_e;

  typedef struct packed {
    logic seq_err;
    logic len_err;
    logic csum_err;
    logic write_ok;
    logic ready;
  } xfer_flags_t;

  // Status class: 0 idle, 1 read, 2 write, 3 err
  function automatic logic [1:0] state_cls(input xfer_state_e s);
    case (s)
      S_IDLE:                 return 2'd0;
      S_RD_FILL, S_RD_READY:  return 2'd1;
      S_ERR:                  return 2'd3;
      default:                return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/ifc_block_xfer_ctrl_if.sv
// ifc_block_xfer_ctrl_if: bundles the IFC register strobe bus and the local
// agent buffer port of the block transfer controller.
//   master: decoder / local agent side (drives strobes, address, local requests)
//   slave : the controller (drives read data, grant, irq, busy)
interface ifc_block_xfer_ctrl_if;
  import ifc_xfer_pkg::*;

  logic              reg_wr_stb;
  logic              reg_rd_stb;
  logic [7:0]        reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  logic              loc_req;
  logic              loc_gnt;
  logic              loc_we;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_rd;
  logic [DATA_W-1:0] loc_rdata;
  logic              loc_done;
  logic [DATA_W-1:0] loc_len;

  logic              irq;
  logic              busy;

  modport master (
    output reg_wr_stb, reg_rd_stb, reg_addr, reg_wdata,
    output loc_req, loc_we, loc_wdata, loc_rd, loc_done, loc_len,
    input  reg_rdata, loc_gnt, loc_rdata, irq, busy
  );

  modport slave (
    input  reg_wr_stb, reg_rd_stb, reg_addr, reg_wdata,
    input  loc_req, loc_we, loc_wdata, loc_rd, loc_done, loc_len,
    output reg_rdata, loc_gnt, loc_rdata, irq, busy
  );
endinterface

// File: rtl/ifc_block_xfer_ctrl_buf.sv
// xfer_buf: DEPTH x 16 block buffer with a fill pointer, a drain pointer and a
// running XOR checksum of every word accepted.
//   clr   : clears both pointers and the checksum (contents are left as-is)
//   we    : store wdata at wr_ptr; ignored once wr_ptr == DEPTH (full)
//   re    : advance rd_ptr, saturating at DEPTH
//   rdata : word at rd_ptr, 0 once rd_ptr has run off the end
module xfer_buf
  import ifc_xfer_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] csum,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         wr_ok;
  logic                         rd_ok;

  assign full  = (wr_ptr == PTR_W'(DEPTH));
  assign wr_ok = we && !full && !clr;
  assign rd_ok = re && (rd_ptr < PTR_W'(DEPTH)) && !clr;
  assign rdata = (rd_ptr < PTR_W'(DEPTH)) ? mem[rd_ptr[AW-1:0]] : '0;

  // Storage has no reset; only pointers and checksum are defined after reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      csum   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      csum   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        csum   <= csum ^ wdata;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ifc_block_xfer_ctrl.sv
// ifc_block_xfer_ctrl: sequences IFC block reads/writes through the register
// window (0x40 ctrl/status, 0x50 csum, 0x52 byte length, 0x54 data port) and
// arbitrates the shared block buffer between the IFC host and the local agent.
//   clock_50MHz : system clock
//   rst_n       : async active-low reset, aborts any transfer
//   bus         : slave side of ifc_block_xfer_ctrl_if (register strobes,
//                 local agent fill/drain port, irq, busy)
module ifc_block_xfer_ctrl
  import ifc_xfer_pkg::*;
#(
  parameter int DEPTH   = 6,
  parameter int PTR_W   = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic                 clock_50MHz,
  input  logic                 rst_n,
  ifc_block_xfer_ctrl_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(2 * DEPTH);
  localparam int          TW      = $clog2(TIMEOUT + 1);

  xfer_state_e       state, nxt;
  xfer_flags_t       flg;
  logic              key;
  logic [15:0]       len, exp_csum;
  logic [TW-1:0]     tmo_cnt;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] buf_rdata, buf_csum, buf_wdata;
  logic              buf_full, buf_clr, buf_we, buf_re;

  // ---------------- event decode ----------------
  logic at_ctrl, at_csum, at_len, at_data;
  logic host_ctl, key_wr, cmd_end, cmd_rd, cmd_wr;
  logic loc_act, gnt, l_we, l_rd, l_done;
  logic h_data_wr, h_data_rd, h_csum_wr, h_len_wr, h_data_bad;
  logic [16:0] len_words, wr_cnt, rd_cnt;
  logic wr_room, rd_left, wr_last, drain_done, tmo, csum_ok;
  logic len_bad_h, loc_len_bad;

  assign at_ctrl = (bus.reg_addr == ADDR_CTRL);
  assign at_csum = (bus.reg_addr == ADDR_CSUM);
  assign at_len  = (bus.reg_addr == ADDR_LEN);
  assign at_data = (bus.reg_addr == ADDR_DATA);

  // Any 0x40 write owns the cycle: every other event is masked by host_ctl.
  assign host_ctl = bus.reg_wr_stb && at_ctrl;
  assign key_wr   = host_ctl && bus.reg_wdata[KEY_BIT];
  assign cmd_end  = host_ctl && (bus.reg_wdata == CMD_END);
  assign cmd_rd   = host_ctl && (bus.reg_wdata == CMD_RD) && (state == S_IDLE);
  assign cmd_wr   = host_ctl && (bus.reg_wdata == CMD_WR) && (state == S_IDLE);

  assign loc_act = (state == S_RD_FILL) || (state == S_WR_DRAIN);
  assign gnt     = loc_act && bus.loc_req;
  assign l_we    = gnt && bus.loc_we   && (state == S_RD_FILL)  && !host_ctl;
  assign l_done  = gnt && bus.loc_done && (state == S_RD_FILL)  && !host_ctl;
  assign l_rd    = gnt && bus.loc_rd   && (state == S_WR_DRAIN) && !host_ctl;

  assign h_data_wr  = bus.reg_wr_stb && at_data && (state == S_WR_RECV);
  assign h_data_rd  = bus.reg_rd_stb && at_data && (state == S_RD_READY);
  assign h_csum_wr  = bus.reg_wr_stb && at_csum && (state == S_WR_RECV);
  assign h_len_wr   = bus.reg_wr_stb && at_len  && (state == S_WR_RECV);
  assign h_data_bad = (bus.reg_wr_stb || bus.reg_rd_stb) && at_data && loc_act;

  // Byte length rounded up to whole words; 17 bits so 0xFFFF cannot wrap.
  assign len_words   = ({1'b0, len} + 17'd1) >> 1;
  assign wr_cnt      = 17'(wr_ptr);
  assign rd_cnt      = 17'(rd_ptr);
  assign wr_room     = wr_cnt < len_words;
  assign rd_left     = rd_cnt < len_words;
  assign wr_last     = h_data_wr && wr_room && (wr_cnt + 17'd1 == len_words);
  assign drain_done  = (state == S_WR_DRAIN) && !host_ctl &&
                       ((l_rd && (rd_cnt + 17'd1 >= len_words)) || !rd_left);
  assign tmo         = loc_act && !(l_we || l_rd) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign csum_ok     = (buf_csum == exp_csum);
  assign len_bad_h   = bus.reg_wdata > MAX_LEN;
  assign loc_len_bad = bus.loc_len > MAX_LEN;

  // ---------------- buffer ----------------
  assign buf_we    = l_we || (h_data_wr && wr_room);
  assign buf_wdata = (state == S_RD_FILL) ? bus.loc_wdata : bus.reg_wdata;
  assign buf_re    = (l_rd || h_data_rd) && rd_left;
  assign buf_clr   = cmd_end || cmd_rd || cmd_wr || drain_done;

  xfer_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_buf (
    .clk    (clock_50MHz),
    .rst_n  (rst_n),
    .clr    (buf_clr),
    .we     (buf_we),
    .wdata  (buf_wdata),
    .re     (buf_re),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .rdata  (buf_rdata),
    .csum   (buf_csum),
    .full   (buf_full)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock_50MHz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    nxt = state;
    if (cmd_end)      nxt = S_IDLE;
    else if (cmd_rd)  nxt = S_RD_FILL;
    else if (cmd_wr)  nxt = S_WR_RECV;
    else if (!host_ctl) begin
      case (state)
        S_RD_FILL: begin
          if (l_done)   nxt = loc_len_bad ? S_ERR : S_RD_READY;
          else if (tmo) nxt = S_ERR;
        end
        S_WR_RECV: begin
          if (h_len_wr) begin
            if (len_bad_h)                nxt = S_ERR;
            else if (bus.reg_wdata == '0) nxt = S_WR_CHECK;
          end else if (wr_last) begin
            nxt = S_WR_CHECK;
          end
        end
        S_WR_CHECK: nxt = csum_ok ? S_WR_DRAIN : S_ERR;
        S_WR_DRAIN: begin
          if (drain_done) nxt = S_IDLE;
          else if (tmo)   nxt = S_ERR;
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  logic [15:0] status;
  always_comb begin
    status               = '0;
    status[ST_KEY]       = key;
    status[ST_READY]     = flg.ready;
    status[ST_WOK]       = flg.write_ok;
    status[ST_CERR]      = flg.csum_err;
    status[ST_LERR]      = flg.len_err;
    status[ST_SERR]      = flg.seq_err;
    status[ST_CLS +: 2]  = state_cls(state);

    bus.loc_gnt   = gnt;
    bus.busy      = (state != S_IDLE);
    bus.irq       = (|flg) || (state == S_ERR);
    bus.loc_rdata = (state == S_WR_DRAIN) ? buf_rdata : '0;

    case (bus.reg_addr)
      ADDR_CTRL: bus.reg_rdata = status;
      ADDR_CSUM: bus.reg_rdata = (state_cls(state) == 2'd2) ? exp_csum : buf_csum;
      ADDR_LEN:  bus.reg_rdata = len;
      ADDR_DATA: bus.reg_rdata = ((state == S_RD_READY) && rd_left) ? buf_rdata : '0;
      default:   bus.reg_rdata = '0;
    endcase
  end

  // ---------------- flags, length, expected checksum ----------------
  always_ff @(posedge clock_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      flg      <= '0;
      key      <= 1'b0;
      len      <= '0;
      exp_csum <= '0;
    end else begin
      if (key_wr) key <= 1'b1;
      if (cmd_end || cmd_rd || cmd_wr) begin
        flg       <= '0;
        flg.ready <= cmd_wr;   // host may start sending as soon as write opens
        len       <= '0;
        exp_csum  <= '0;
      end else if (!host_ctl) begin
        if (h_data_bad) flg.seq_err <= 1'b1;
        case (state)
          S_RD_FILL: begin
            if (l_we && buf_full) flg.seq_err <= 1'b1;
            if (l_done) begin
              if (loc_len_bad) flg.len_err <= 1'b1;
              else begin
                len       <= bus.loc_len;
                flg.ready <= 1'b1;
              end
            end
          end
          S_RD_READY: if (h_data_rd && !rd_left) flg.seq_err <= 1'b1;
          S_WR_RECV: begin
            if (h_csum_wr) exp_csum <= bus.reg_wdata;
            if (h_len_wr) begin
              len <= bus.reg_wdata;
              if (len_bad_h) flg.len_err <= 1'b1;
            end
            if (h_data_wr && !wr_room) flg.seq_err <= 1'b1;
          end
          S_WR_CHECK: begin
            if (csum_ok) flg.write_ok <= 1'b1;
            else         flg.csum_err <= 1'b1;
          end
          default: ;
        endcase
        // ready means "host may move data"; it drops once that phase ends.
        if (nxt == S_ERR || nxt == S_WR_CHECK) flg.ready <= 1'b0;
      end
    end
  end

  // Local inactivity timer; any granted fill/drain beat restarts it.
  always_ff @(posedge clock_50MHz or negedge rst_n) begin
    if (!rst_n)                        tmo_cnt <= '0;
    else if (!loc_act || l_we || l_rd) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ifc_block_xfer_ctrl.sv
module tb_ifc_block_xfer_ctrl;
  import ifc_xfer_pkg::*;

  localparam int DEPTH   = 6;
  localparam int TIMEOUT = 50000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifc_block_xfer_ctrl_if bus();

  ifc_block_xfer_ctrl #(.DEPTH(DEPTH), .PTR_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clock_50MHz (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] blk [6] = '{16'h0112, 16'h3344, 16'h5566, 16'h0223, 16'h7788, 16'h99AA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [15:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      chk(tag, 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [15:0] d);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wr_stb = 1'b1;
    @(negedge clk);
    bus.reg_wr_stb = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [15:0] d);
    bus.reg_addr = a; bus.reg_rd_stb = 1'b1;
    #1 d = bus.reg_rdata;
    @(negedge clk);
    bus.reg_rd_stb = 1'b0;
  endtask

  task automatic stat_chk(input string tag, input logic [15:0] exp);
    bus.reg_addr = ADDR_CTRL;
    #1 chk(tag, 32'(bus.reg_rdata), 32'(exp));
  endtask

  task automatic write_block(input logic [15:0] cs, input bit push);
    reg_write(8'h40, 16'h0105);
    reg_write(8'h50, cs);
    reg_write(8'h52, 16'd12);
    for (int i = 0; i < 6; i++) begin
      reg_write(8'h54, blk[i]);
      if (push) exp_q.push_back(blk[i]);
    end
  endtask

  task automatic drain(input int n);
    bus.loc_req = 1'b1;
    #1 chk("drain_gnt", 32'(bus.loc_gnt), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.loc_rd = 1'b1;
      #1 chk_pop("drain_data", bus.loc_rdata);
      @(negedge clk);
    end
    bus.loc_rd = 1'b0;
    bus.loc_req = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int n;
    bus.reg_wr_stb = 0; bus.reg_rd_stb = 0; bus.reg_addr = 8'h40; bus.reg_wdata = 0;
    bus.loc_req = 0; bus.loc_we = 0; bus.loc_wdata = 0; bus.loc_rd = 0;
    bus.loc_done = 0; bus.loc_len = 0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stat_chk("rst_status", 16'h0000);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_gnt", 32'(bus.loc_gnt), 0);

    // Keyless control write is ignored
    reg_write(8'h40, 16'h0005);
    chk("nokey_busy", 32'(bus.busy), 0);

    // Write block, good checksum
    reg_write(8'h40, 16'h0105);
    stat_chk("wr_open_status", 16'h0508);
    chk("wr_open_irq", 32'(bus.irq), 1);
    reg_write(8'h50, 16'h8B31);
    reg_write(8'h52, 16'd12);
    for (int i = 0; i < 6; i++) begin
      reg_write(8'h54, blk[i]);
      exp_q.push_back(blk[i]);
    end
    @(negedge clk);
    stat_chk("wr_ok_status", 16'h0510);
    chk("wr_ok_irq", 32'(bus.irq), 1);
    drain(6);
    chk("drain_idle_busy", 32'(bus.busy), 0);
    reg_write(8'h40, 16'h0100);
    stat_chk("end_status", 16'h0100);
    chk("end_irq", 32'(bus.irq), 0);

    // Write block, bad checksum
    write_block(16'h8B30, 1'b0);
    @(negedge clk);
    stat_chk("csum_err_status", 16'h0720);
    reg_write(8'h40, 16'h0100);
    stat_chk("csum_end_status", 16'h0100);
    chk("csum_end_busy", 32'(bus.busy), 0);

    // Read block; last fill beat coincides with loc_done
    reg_write(8'h40, 16'h0103);
    stat_chk("rd_open_status", 16'h0300);
    bus.loc_req = 1'b1;
    #1 chk("fill_gnt", 32'(bus.loc_gnt), 1);
    for (int i = 0; i < 6; i++) begin
      bus.loc_we = 1'b1; bus.loc_wdata = blk[i];
      if (i == 5) begin bus.loc_done = 1'b1; bus.loc_len = 16'd12; end
      exp_q.push_back(blk[i]);
      @(negedge clk);
    end
    bus.loc_we = 0; bus.loc_done = 0; bus.loc_req = 0;
    stat_chk("rd_ready_status", 16'h0308);
    chk("rd_ready_irq", 32'(bus.irq), 1);
    reg_read(8'h52, d); chk("rd_len", 32'(d), 32'd12);
    reg_read(8'h50, d); chk("rd_csum", 32'(d), 32'h8B31);
    for (int i = 0; i < 6; i++) begin
      reg_read(8'h54, d); chk_pop("rd_data", d);
    end
    reg_read(8'h54, d); chk("rd_past_end", 32'(d), 0);
    stat_chk("rd_past_status", 16'h0388);
    reg_write(8'h40, 16'h0100);

    // Oversize lengths
    reg_write(8'h40, 16'h0105);
    reg_write(8'h52, 16'd14);
    stat_chk("wr_len14_status", 16'h0740);
    reg_write(8'h40, 16'h0100);
    reg_write(8'h40, 16'h0103);
    bus.loc_req = 1; bus.loc_done = 1; bus.loc_len = 16'd13;
    @(negedge clk);
    bus.loc_done = 0; bus.loc_req = 0;
    stat_chk("rd_len13_status", 16'h0740);
    reg_write(8'h40, 16'h0100);

    // Host data read during fill: flagged, drain pointer untouched
    reg_write(8'h40, 16'h0103);
    bus.loc_req = 1;
    reg_read(8'h54, d); chk("fill_hostrd_data", 32'(d), 0);
    stat_chk("fill_hostrd_status", 16'h0380);
    bus.loc_we = 1; bus.loc_wdata = 16'hABCD; bus.loc_done = 1; bus.loc_len = 16'd2;
    exp_q.push_back(16'hABCD);
    @(negedge clk);
    bus.loc_we = 0; bus.loc_done = 0; bus.loc_req = 0;
    stat_chk("fill_hostrd_ready", 16'h0388);
    reg_read(8'h54, d); chk_pop("fill_hostrd_word", d);
    reg_write(8'h40, 16'h0100);

    // Local inactivity timeout
    reg_write(8'h40, 16'h0103);
    bus.loc_req = 1;
    bus.reg_addr = ADDR_CTRL;
    n = 0;
    while (bus.reg_rdata[10:9] != 2'd3 && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
    stat_chk("tmo_status", 16'h0700);
    chk("tmo_irq", 32'(bus.irq), 1);
    bus.loc_req = 0;
    reg_write(8'h40, 16'h0100);

    // Asynchronous reset mid-write, then a clean transfer
    reg_write(8'h40, 16'h0105);
    reg_write(8'h50, 16'h8B31);
    reg_write(8'h52, 16'd12);
    for (int i = 0; i < 3; i++) reg_write(8'h54, blk[i]);
    bus.reg_addr = ADDR_CTRL;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_status", 32'(bus.reg_rdata), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_irq", 32'(bus.irq), 0);
    chk("arst_gnt", 32'(bus.loc_gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_block(16'h8B31, 1'b1);
    @(negedge clk);
    stat_chk("post_rst_status", 16'h0510);
    drain(6);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
